// File: rtl/sum_block_accumulator_if.sv
// Handshake bundle for sum_block_accumulator.
//   in_valid/in_data/in_ready : incoming operand sums (valid/ready, sink side is the block)
//   flush                     : close the current block early
//   out_valid/out_data/out_last/out_ovf/out_ready : byte-serial result stream, LSB first
// The master modport is the environment (sum stage + downstream reader),
// the slave modport is the accumulator block.
interface sum_block_accumulator_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              flush;
  logic              out_valid;
  logic [7:0]        out_data;
  logic              out_last;
  logic              out_ovf;
  logic              out_ready;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_ovf
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_data, out_last, out_ovf
  );
endinterface

// File: rtl/sum_block_accumulator.sv
// Accumulates BLOCK_LEN unsigned sums (fewer on flush) into an ACC_W-bit total
// and streams the total out byte-serially, LSB first.
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : sum_block_accumulator_if.slave (input sums, flush, output byte stream)
module sum_block_accumulator #(
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 16,
  parameter int BLOCK_LEN = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  sum_block_accumulator_if.slave      bus
);
  localparam int NBYTES = ACC_W / 8;
  localparam int CNT_W  = $clog2(BLOCK_LEN + 1);
  localparam int BI_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic {ACCUM = 1'b0, SEND = 1'b1} state_t;

  state_t             state_q,    state_d;
  logic [ACC_W-1:0]   acc_q,      acc_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;
  logic               ovf_q,      ovf_d;
  logic [BI_W-1:0]    byte_idx_q, byte_idx_d;
  logic [ACC_W-1:0]   shadow_q,   shadow_d;

  logic [ACC_W:0]     sum_w;
  logic [CNT_W-1:0]   cnt_inc;
  logic               accept;
  logic               close;
  logic               is_last;
  logic [7:0]         sel_byte;

  // One extra bit keeps the carry out of the accumulator for the sticky overflow flag.
  assign sum_w   = {1'b0, acc_q} + {{(ACC_W + 1 - DATA_W){1'b0}}, bus.in_data};
  assign cnt_inc = cnt_q + 1'b1;
  assign accept  = (state_q == ACCUM) && bus.in_valid;
  // A flush only closes a block that would be non-empty after this cycle.
  assign close   = (accept && ((cnt_inc == CNT_W'(BLOCK_LEN)) || bus.flush)) ||
                   ((state_q == ACCUM) && !bus.in_valid && bus.flush && (cnt_q != '0));
  assign is_last  = (byte_idx_q == BI_W'(NBYTES - 1));
  assign sel_byte = 8'(shadow_q >> {byte_idx_q, 3'b000});

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    byte_idx_d = byte_idx_q;
    shadow_d   = shadow_q;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          acc_d = sum_w[ACC_W-1:0];
          ovf_d = ovf_q | sum_w[ACC_W];
          cnt_d = cnt_inc;
        end
        // acc_d already includes a sample accepted this cycle.
        if (close) begin
          shadow_d   = acc_d;
          byte_idx_d = '0;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (bus.out_ready) begin
          if (is_last) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
          end
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ACCUM;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      byte_idx_q <= '0;
      shadow_q   <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      byte_idx_q <= byte_idx_d;
      shadow_q   <= shadow_d;
    end
  end

  // Outputs are decoded purely from registered state.
  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == SEND);
  assign bus.out_data  = (state_q == SEND) ? sel_byte : 8'h00;
  assign bus.out_last  = (state_q == SEND) && is_last;
  assign bus.out_ovf   = (state_q == SEND) && ovf_q;
endmodule

// File: tb/tb_sum_block_accumulator.sv
// Bench for sum_block_accumulator: instance 0 uses defaults (ACC_W=16),
// instance 1 uses ACC_W=8 to reach accumulator wrap-around.
module tb_sum_block_accumulator;
  localparam int BL = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sum_block_accumulator_if #(.DATA_W(8)) if0 ();
  sum_block_accumulator_if #(.DATA_W(8)) if1 ();

  sum_block_accumulator #(.DATA_W(8), .ACC_W(16), .BLOCK_LEN(BL)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave));
  sum_block_accumulator #(.DATA_W(8), .ACC_W(8), .BLOCK_LEN(BL)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave));

  int n_checks = 0;
  int n_err    = 0;

  // Model: running sum, count, sticky overflow and a queue of bytes still to be
  // delivered (data | last<<8 | ovf<<9). A non-empty queue means "reading out".
  int m_acc [2];
  int m_cnt [2];
  int m_ovf [2];
  int mq    [2][$];
  int got   [2][$];
  int accw  [2] = '{16, 8};

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(int k, bit rn, bit v, int d, bit f, bit r);
    int nb = accw[k] / 8;
    int s;
    if (!rn) begin
      m_acc[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0;
      mq[k].delete();
    end else if (mq[k].size() > 0) begin
      if (r) begin
        void'(mq[k].pop_front());
        if (mq[k].size() == 0) begin
          m_acc[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0;
        end
      end
    end else begin
      if (v) begin
        s = m_acc[k] + d;
        if (s >= (1 << accw[k])) begin
          m_ovf[k] = 1;
          s -= (1 << accw[k]);
        end
        m_acc[k] = s;
        m_cnt[k]++;
      end
      if ((v && m_cnt[k] == BL) || (f && m_cnt[k] > 0))
        for (int i = 0; i < nb; i++)
          mq[k].push_back(((m_acc[k] >> (8 * i)) & 255) |
                          ((i == nb - 1) ? 256 : 0) | (m_ovf[k] << 9));
    end
  endtask

  task automatic compare(int k, bit ir, bit ov, int od, bit ol, bit oo);
    bit busy = (mq[k].size() > 0);
    int e    = busy ? mq[k][0] : 0;
    string p = (k == 0) ? "d0" : "d1";
    chk({p, ".in_ready"},  int'(ir), int'(!busy));
    chk({p, ".out_valid"}, int'(ov), int'(busy));
    chk({p, ".out_data"},  od,       e & 255);
    chk({p, ".out_last"},  int'(ol), (e >> 8) & 1);
    if (busy) chk({p, ".out_ovf"}, int'(oo), (e >> 9) & 1);
  endtask

  // Inputs change only on the falling edge, so they are stable here.
  always @(posedge clk) begin
    if (rst_n && if0.out_valid && if0.out_ready)
      got[0].push_back(int'(if0.out_data) | (int'(if0.out_last) << 8) | (int'(if0.out_ovf) << 9));
    if (rst_n && if1.out_valid && if1.out_ready)
      got[1].push_back(int'(if1.out_data) | (int'(if1.out_last) << 8) | (int'(if1.out_ovf) << 9));
    model_step(0, rst_n, if0.in_valid, int'(if0.in_data), if0.flush, if0.out_ready);
    model_step(1, rst_n, if1.in_valid, int'(if1.in_data), if1.flush, if1.out_ready);
    #1;
    compare(0, if0.in_ready, if0.out_valid, int'(if0.out_data), if0.out_last, if0.out_ovf);
    compare(1, if1.in_ready, if1.out_valid, int'(if1.out_data), if1.out_last, if1.out_ovf);
  end

  task automatic step0(bit v, int d, bit f, bit r);
    if0.in_valid = v; if0.in_data = 8'(d); if0.flush = f; if0.out_ready = r;
    @(negedge clk);
  endtask

  task automatic step1(bit v, int d, bit f, bit r);
    if1.in_valid = v; if1.in_data = 8'(d); if1.flush = f; if1.out_ready = r;
    @(negedge clk);
  endtask

  task automatic idle0(int n);
    for (int i = 0; i < n; i++) step0(1'b0, 0, 1'b0, 1'b1);
  endtask

  task automatic idle1(int n);
    for (int i = 0; i < n; i++) step1(1'b0, 0, 1'b0, 1'b1);
  endtask

  // Compares the transferred bytes of instance k against hand-computed literals.
  task automatic chk_got(string name, int k, int n, int b0, int b1);
    chk({name, ".count"}, got[k].size(), n);
    if (n > 0 && got[k].size() > 0) chk({name, ".byte0"}, got[k][0], b0);
    if (n > 1 && got[k].size() > 1) chk({name, ".byte1"}, got[k][1], b1);
    got[k].delete();
  endtask

  initial begin
    rst_n = 1'b0;
    if0.in_valid = 0; if0.in_data = 0; if0.flush = 0; if0.out_ready = 1;
    if1.in_valid = 0; if1.in_data = 0; if1.flush = 0; if1.out_ready = 1;
    repeat (2) @(negedge clk);
    chk("reset.in_ready",  int'(if0.in_ready),  1);
    chk("reset.out_valid", int'(if0.out_valid), 0);
    chk("reset.out_data",  int'(if0.out_data),  0);
    rst_n = 1'b1;
    idle0(1);

    // Basic block: 10+20+30+40 = 100 = 0x0064.
    step0(1, 10, 0, 1); step0(1, 20, 0, 1); step0(1, 30, 0, 1); step0(1, 40, 0, 1);
    chk("basic.first_byte", int'(if0.out_data), 'h64);
    idle0(3);
    chk_got("basic", 0, 2, 'h64, 'h100);

    // Back-pressure: output holds, offered samples are not consumed.
    step0(1, 10, 0, 0); step0(1, 20, 0, 0); step0(1, 30, 0, 0); step0(1, 40, 0, 0);
    for (int i = 0; i < 5; i++) begin
      chk("bp.hold_data",  int'(if0.out_data),  'h64);
      chk("bp.hold_valid", int'(if0.out_valid), 1);
      step0(1, 99, 0, 0);
    end
    idle0(3);
    chk_got("bp", 0, 2, 'h64, 'h100);

    // Flush after two samples, flush with a sample, and flush on an empty block.
    step0(1, 5, 0, 1); step0(1, 6, 0, 1); step0(0, 0, 1, 1);
    idle0(3);
    chk_got("flush_alone", 0, 2, 'h0B, 'h100);
    step0(1, 7, 1, 1);
    idle0(3);
    chk_got("flush_with_sample", 0, 2, 'h07, 'h100);
    step0(0, 0, 1, 1); step0(0, 0, 1, 1);
    idle0(3);
    chk_got("flush_empty", 0, 0, 0, 0);

    // Maximum sample values: 4*255 = 1020 = 0x03FC.
    for (int i = 0; i < 4; i++) step0(1, 255, 0, 1);
    idle0(3);
    chk_got("max", 0, 2, 'hFC, 'h103);

    // Reset after the first byte has transferred; the second byte is abandoned.
    step0(1, 10, 0, 1); step0(1, 20, 0, 1); step0(1, 30, 0, 1); step0(1, 40, 0, 1);
    step0(0, 0, 0, 1);
    chk("rst_mid.valid_before", int'(if0.out_valid), 1);
    rst_n = 1'b0;
    step0(0, 0, 0, 0);
    rst_n = 1'b1;
    chk("rst_mid.out_valid", int'(if0.out_valid), 0);
    chk("rst_mid.in_ready",  int'(if0.in_ready),  1);
    chk_got("rst_mid.partial", 0, 1, 'h64, 0);
    step0(1, 1, 0, 1); step0(1, 2, 0, 1); step0(1, 3, 0, 1); step0(1, 4, 0, 1);
    idle0(3);
    chk_got("after_rst", 0, 2, 'h0A, 'h100);

    // 8-bit accumulator: 200+100 = 300 wraps to 0x2C with overflow.
    step1(1, 200, 0, 1); step1(1, 100, 0, 1); step1(1, 0, 0, 1); step1(1, 0, 0, 1);
    idle1(3);
    chk_got("ovf", 1, 1, 'h32C, 0);
    for (int i = 0; i < 4; i++) step1(1, 1, 0, 1);
    idle1(3);
    chk_got("ovf_cleared", 1, 1, 'h104, 0);

    // Randomized traffic on both instances; the per-cycle compare does the checking.
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      if0.in_valid = ($urandom_range(0, 9) < 7);
      if0.in_data  = 8'($urandom_range(0, 255));
      if0.flush    = ($urandom_range(0, 9) == 0);
      if0.out_ready = ($urandom_range(0, 9) < 6);
      if1.in_valid = ($urandom_range(0, 9) < 7);
      if1.in_data  = 8'($urandom_range(0, 255));
      if1.flush    = ($urandom_range(0, 9) == 0);
      if1.out_ready = ($urandom_range(0, 9) < 6);
      @(negedge clk);
    end
    rst_n = 1'b1;
    idle0(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
